mf8_reg_wb: RTL and testbench

//  Writeback sequencer: the initiator for the mf8 register-file write port.
//  - Accepts byte or 16-bit register-pair results (ADIW/SBIW, MOVW, MUL, Z/X/Y post-inc) via valid/ready.
//  - Serialises them onto the register file's single 8-bit write port.
//  - Honours the register file's protocol: write address in cycle N, Wr + data in cycle N+1.
//  - Sits between the execute stage and the register file; owns the shared Rd address bus while writing.

---
 rtl/mf8_reg_wb_pkg.sv | 26 ++
 rtl/mf8_reg_wb_if.sv | 12 +
 rtl/mf8_wb_skid.sv | 28 ++
 rtl/mf8_reg_wb.sv | 93 +++++++++
 tb/tb_mf8_reg_wb.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mf8_reg_wb_pkg.sv
// Shared types for the mf8 register-file writeback sequencer.
// Covers the state encoding, register constants, the request entry and address helpers.
package mf8_reg_wb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] REG_ZL = 5'd30;
  localparam logic [ADDR_W-1:0] REG_ZH = 5'd31;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WLO, ST_WHI} wb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [2*DATA_W-1:0] data;
    logic                word;
  } wb_req_t;

  // A pair write always starts at the even register of the pair.
  function automatic logic [ADDR_W-1:0] lo_addr(input wb_req_t r);
    return r.word ? {r.addr[ADDR_W-1:1], 1'b0} : r.addr;
  endfunction

  function automatic logic [ADDR_W-1:0] hi_addr(input wb_req_t r);
    return {r.addr[ADDR_W-1:1], 1'b1};
  endfunction
endpackage

// File: rtl/mf8_reg_wb_if.sv
// Request channel from the execute stage into the writeback sequencer.
interface mf8_reg_wb_if;
  import mf8_reg_wb_pkg::*;
  logic                Req_Valid;
  logic                Req_Ready;
  logic [ADDR_W-1:0]   Req_Addr;
  logic [2*DATA_W-1:0] Req_Data;
  logic                Req_Word;

  modport master (output Req_Valid, Req_Addr, Req_Data, Req_Word, input Req_Ready);
  modport slave  (input Req_Valid, Req_Addr, Req_Data, Req_Word, output Req_Ready);
endinterface

// File: rtl/mf8_wb_skid.sv
// One-entry pending buffer in front of the writeback sequencer.
// It accepts a new entry in the same cycle the old one is popped.
module mf8_wb_skid
  import mf8_reg_wb_pkg::*;
(
  input  logic    Clk,
  input  logic    Reset_n,
  input  logic    push_valid,
  input  wb_req_t push_req,
  output logic    push_ready,
  input  logic    pop,
  output logic    p_valid,
  output wb_req_t p_req
);
  assign push_ready = ~p_valid | pop;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p_valid <= 1'b0;
      p_req   <= '0;
    end else if (push_valid && push_ready) begin
      p_valid <= 1'b1;
      p_req   <= push_req;
    end else if (pop) begin
      p_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mf8_reg_wb.sv
// Writeback sequencer that serialises byte and pair results onto the 8-bit register-file port.
// The register file takes the address one cycle before the write strobe and data.
module mf8_reg_wb
  import mf8_reg_wb_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  mf8_reg_wb_if.slave       req,
  output logic              Rf_Addr_Own,
  output logic [ADDR_W-1:0] Rf_Addr,
  output logic              Rf_Wr,
  output logic [DATA_W-1:0] Rf_Data,
  output logic              Busy,
  output logic              Done
);
  wb_state_e state;
  wb_req_t   cur, p_req, push_req;
  logic      p_valid, pop, last_wr;

  assign push_req = {req.Req_Addr, req.Req_Data, req.Req_Word};

  mf8_wb_skid u_skid (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .push_valid (req.Req_Valid),
    .push_req   (push_req),
    .push_ready (req.Req_Ready),
    .pop        (pop),
    .p_valid    (p_valid),
    .p_req      (p_req)
  );

  assign last_wr = (state == ST_WLO && !cur.word) || state == ST_WHI;
  assign pop     = p_valid && (state == ST_IDLE || last_wr);
  assign Busy    = p_valid | (state != ST_IDLE);

  // A fresh request presents its address straight from P while still idle.
  // This keeps the first write at accept+2. ST_ADDR covers a current entry that still needs its address phase.
  always_comb begin
    Rf_Addr_Own = 1'b0;
    Rf_Addr     = '0;
    Rf_Wr       = 1'b0;
    Rf_Data     = '0;
    Done        = 1'b0;
    case (state)
      ST_IDLE: if (p_valid) begin
        Rf_Addr_Own = 1'b1;
        Rf_Addr     = lo_addr(p_req);
      end
      ST_ADDR: begin
        Rf_Addr_Own = 1'b1;
        Rf_Addr     = lo_addr(cur);
      end
      ST_WLO: begin
        Rf_Wr   = 1'b1;
        Rf_Data = cur.data[DATA_W-1:0];
        if (cur.word) begin
          Rf_Addr_Own = 1'b1;
          Rf_Addr     = hi_addr(cur);
        end else begin
          Done = 1'b1;
        end
      end
      ST_WHI: begin
        Rf_Wr   = 1'b1;
        Rf_Data = cur.data[2*DATA_W-1:DATA_W];
        Done    = 1'b1;
      end
      default: ;
    endcase
    // The next request's address phase overlaps the final write of this one.
    if (last_wr && p_valid) begin
      Rf_Addr_Own = 1'b1;
      Rf_Addr     = lo_addr(p_req);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else if (pop) begin
      cur   <= p_req;
      state <= ST_WLO;
    end else begin
      case (state)
        ST_ADDR: state <= ST_WLO;
        ST_WLO:  state <= cur.word ? ST_WHI : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mf8_reg_wb.sv
// Bench for mf8_reg_wb, paired with a behavioural register file.
// That register file latches the address in one cycle and writes in the next.
module tb_mf8_reg_wb;
  import mf8_reg_wb_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  mf8_reg_wb_if req_if ();
  logic              Rf_Addr_Own, Rf_Wr, Busy, Done;
  logic [ADDR_W-1:0] Rf_Addr;
  logic [DATA_W-1:0] Rf_Data;

  mf8_reg_wb dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .req         (req_if.slave),
    .Rf_Addr_Own (Rf_Addr_Own),
    .Rf_Addr     (Rf_Addr),
    .Rf_Wr       (Rf_Wr),
    .Rf_Data     (Rf_Data),
    .Busy        (Busy),
    .Done        (Done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural register file.
  logic [7:0] rf [32];
  logic [4:0] addr_q;
  always @(posedge Clk) begin
    if (Rf_Wr) rf[addr_q] <= Rf_Data;
    if (Rf_Addr_Own) addr_q <= Rf_Addr;
  end

  // Scoreboard of expected register writes, in order.
  typedef struct { logic [4:0] a; logic [7:0] d; } wr_t;
  wr_t expq[$];

  always @(negedge Clk) begin
    if (Reset_n && Rf_Wr) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h/%h required=none", addr_q, Rf_Data);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("sb_addr", 32'(addr_q), 32'(e.a));
        chk("sb_data", 32'(Rf_Data), 32'(e.d));
      end
    end
  end

  task automatic req_push(input logic [4:0] a, input logic [15:0] d, input logic w);
    req_if.Req_Valid = 1'b1;
    req_if.Req_Addr  = a;
    req_if.Req_Data  = d;
    req_if.Req_Word  = w;
    if (w) begin
      expq.push_back('{{a[4:1], 1'b0}, d[7:0]});
      expq.push_back('{{a[4:1], 1'b1}, d[15:8]});
    end else begin
      expq.push_back('{a, d[7:0]});
    end
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] a; logic [15:0] d; logic w;
    logic [4:0] ea0; logic [7:0] ed0; logic [4:0] ea1; logic [7:0] ed1;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int n;
    tbl[0] = '{5'd26, 16'h0055, 1'b0, 5'd26, 8'h55, 5'd0,  8'h00};
    tbl[1] = '{5'd29, 16'h0099, 1'b0, 5'd29, 8'h99, 5'd0,  8'h00};
    tbl[2] = '{5'd25, 16'hBEEF, 1'b1, 5'd24, 8'hEF, 5'd25, 8'hBE};
    tbl[3] = '{5'd0,  16'hFF01, 1'b0, 5'd0,  8'h01, 5'd0,  8'h00};
    tbl[4] = '{5'd1,  16'hA55A, 1'b1, 5'd0,  8'h5A, 5'd1,  8'hA5};
    tbl[5] = '{5'd31, 16'h00C3, 1'b0, 5'd31, 8'hC3, 5'd0,  8'h00};

    req_if.Req_Valid = 1'b0;
    req_if.Req_Addr  = '0;
    req_if.Req_Data  = '0;
    req_if.Req_Word  = 1'b0;

    #2;
    chk("rst_ready", 32'(req_if.Req_Ready), 1);
    chk("rst_own",   32'(Rf_Addr_Own), 0);
    chk("rst_wr",    32'(Rf_Wr), 0);
    chk("rst_busy",  32'(Busy), 0);
    chk("rst_done",  32'(Done), 0);
    chk("rst_addr",  32'(Rf_Addr), 0);
    chk("rst_data",  32'(Rf_Data), 0);
    nxt();
    Reset_n = 1'b1;
    nxt();

    // Test 1: single byte.
    req_push(5'd5, 16'h00A5, 1'b0);
    @(negedge Clk); chk("t1_ready", 32'(req_if.Req_Ready), 1);
    nxt(); req_if.Req_Valid = 1'b0;
    @(negedge Clk); chk("t1_c1_own", 32'(Rf_Addr_Own), 1); chk("t1_c1_addr", 32'(Rf_Addr), 5);
    chk("t1_c1_wr", 32'(Rf_Wr), 0);
    nxt();
    @(negedge Clk); chk("t1_c2_wr", 32'(Rf_Wr), 1); chk("t1_c2_data", 32'(Rf_Data), 32'h A5);
    chk("t1_c2_done", 32'(Done), 1);
    nxt();
    @(negedge Clk); chk("t1_c3_busy", 32'(Busy), 0); chk("t1_r5", 32'(rf[5]), 32'hA5);
    nxt();

    // Test 2: pair write to Z.
    req_push(REG_ZL, 16'h1234, 1'b1);
    nxt(); req_if.Req_Valid = 1'b0;
    @(negedge Clk); chk("t2_c1_addr", 32'(Rf_Addr), 30); chk("t2_c1_own", 32'(Rf_Addr_Own), 1);
    nxt();
    @(negedge Clk); chk("t2_c2_wr", 32'(Rf_Wr), 1); chk("t2_c2_data", 32'(Rf_Data), 32'h34);
    chk("t2_c2_addr", 32'(Rf_Addr), 31); chk("t2_c2_done", 32'(Done), 0);
    nxt();
    @(negedge Clk); chk("t2_c3_wr", 32'(Rf_Wr), 1); chk("t2_c3_data", 32'(Rf_Data), 32'h12);
    chk("t2_c3_done", 32'(Done), 1);
    nxt();
    @(negedge Clk); chk("t2_zl", 32'(rf[REG_ZL]), 32'h34); chk("t2_zh", 32'(rf[REG_ZH]), 32'h12);
    nxt();

    // Table-driven single requests, each run to completion.
    for (int i = 0; i < 6; i++) begin
      req_push(tbl[i].a, tbl[i].d, tbl[i].w);
      n = 0;
      @(negedge Clk);
      while (!req_if.Req_Ready && n < 20) begin @(negedge Clk); n++; end
      chk("tbl_ready", 32'(req_if.Req_Ready), 1);
      nxt(); req_if.Req_Valid = 1'b0;
      n = 0;
      @(negedge Clk);
      while (Busy && n < 50) begin @(negedge Clk); n++; end
      chk("tbl_idle", 32'(Busy), 0);
      chk("tbl_lo", 32'(rf[tbl[i].ea0]), 32'(tbl[i].ed0));
      if (tbl[i].w) chk("tbl_hi", 32'(rf[tbl[i].ea1]), 32'(tbl[i].ed1));
      nxt();
    end
    chk("t3_r26_kept", 32'(rf[26]), 32'h55);

    // Test 4: back-to-back bytes.
    req_push(5'd1, 16'h0011, 1'b0);
    @(negedge Clk); chk("t4_c0_ready", 32'(req_if.Req_Ready), 1);
    nxt(); req_push(5'd2, 16'h0022, 1'b0);
    @(negedge Clk); chk("t4_c1_ready", 32'(req_if.Req_Ready), 1); chk("t4_c1_addr", 32'(Rf_Addr), 1);
    nxt(); req_push(5'd3, 16'h0033, 1'b0);
    @(negedge Clk); chk("t4_c2_ready", 32'(req_if.Req_Ready), 1); chk("t4_c2_wr", 32'(Rf_Wr), 1);
    chk("t4_c2_done", 32'(Done), 1); chk("t4_c2_data", 32'(Rf_Data), 32'h11);
    nxt(); req_if.Req_Valid = 1'b0;
    @(negedge Clk); chk("t4_c3_wr", 32'(Rf_Wr), 1); chk("t4_c3_done", 32'(Done), 1);
    chk("t4_c3_data", 32'(Rf_Data), 32'h22);
    nxt();
    @(negedge Clk); chk("t4_c4_wr", 32'(Rf_Wr), 1); chk("t4_c4_done", 32'(Done), 1);
    chk("t4_c4_data", 32'(Rf_Data), 32'h33);
    nxt();
    @(negedge Clk); chk("t4_c5_busy", 32'(Busy), 0);
    chk("t4_r1", 32'(rf[1]), 32'h11); chk("t4_r3", 32'(rf[3]), 32'h33);
    nxt();

    // Test 5: word then byte, back-to-back.
    req_push(5'd26, 16'hCAFE, 1'b1);
    @(negedge Clk); chk("t5_c0_ready", 32'(req_if.Req_Ready), 1);
    nxt(); req_push(5'd3, 16'h0077, 1'b0);
    @(negedge Clk); chk("t5_c1_ready", 32'(req_if.Req_Ready), 1);
    nxt(); req_if.Req_Valid = 1'b0;
    @(negedge Clk); chk("t5_c2_ready", 32'(req_if.Req_Ready), 0); chk("t5_c2_data", 32'(Rf_Data), 32'hFE);
    chk("t5_c2_addr", 32'(Rf_Addr), 27); chk("t5_c2_done", 32'(Done), 0);
    nxt();
    @(negedge Clk); chk("t5_c3_ready", 32'(req_if.Req_Ready), 1); chk("t5_c3_data", 32'(Rf_Data), 32'hCA);
    chk("t5_c3_addr", 32'(Rf_Addr), 3); chk("t5_c3_own", 32'(Rf_Addr_Own), 1); chk("t5_c3_done", 32'(Done), 1);
    nxt();
    @(negedge Clk); chk("t5_c4_wr", 32'(Rf_Wr), 1); chk("t5_c4_data", 32'(Rf_Data), 32'h77);
    chk("t5_c4_done", 32'(Done), 1);
    nxt();
    @(negedge Clk); chk("t5_busy", 32'(Busy), 0); chk("t5_r27", 32'(rf[27]), 32'hCA);
    nxt();

    // Test 6: reset during the low-byte write of a pair.
    req_push(5'd28, 16'h1357, 1'b1);
    nxt(); req_if.Req_Valid = 1'b0;
    @(negedge Clk); chk("t6_c1_addr", 32'(Rf_Addr), 28);
    nxt();
    Reset_n = 1'b0;
    #1;
    chk("t6_wr_drop", 32'(Rf_Wr), 0);
    chk("t6_busy_drop", 32'(Busy), 0);
    expq.delete();
    nxt(); nxt();
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("t6_ready", 32'(req_if.Req_Ready), 1);
    chk("t6_busy", 32'(Busy), 0);
    chk("t6_r29_kept", 32'(rf[29]), 32'h99);
    nxt();

    chk("sb_empty", 32'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
